// File: rtl/ddr5_cmd_sched.sv
// DDR5 single-channel in-order command scheduler: request FIFO, two-cycle
// ACT/CAS command sequencing, timing enforcement and optional open-page table.
module ddr5_cmd_sched #(
    parameter int QDEPTH    = 16,
    parameter int CORE_W    = 3,
    parameter int BG_W      = 3,
    parameter int BA_W      = 2,
    parameter int ROW_W     = 16,
    parameter int COL_W     = 10,
    parameter int TW        = 9,
    parameter int T_RCD     = 78,
    parameter int T_CAS     = 80,
    parameter int T_CWD     = 76,
    parameter int T_BURST   = 16,
    parameter int T_WR      = 60,
    parameter int T_RAS     = 152,
    parameter int T_RP      = 78,
    parameter int OPEN_PAGE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_opn,
    input  logic [CORE_W-1:0]         req_core,
    input  logic [BG_W-1:0]           req_bg,
    input  logic [BA_W-1:0]           req_ba,
    input  logic [ROW_W-1:0]          req_row,
    input  logic [COL_W-1:0]          req_col,
    output logic                      cmd_valid,
    output logic [2:0]                cmd_code,
    output logic [BG_W-1:0]           cmd_bg,
    output logic [BA_W-1:0]           cmd_ba,
    output logic [ROW_W-1:0]          cmd_addr,
    output logic                      rsp_valid,
    output logic [CORE_W-1:0]         rsp_core,
    output logic                      err_drop,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy
);

    localparam int QAW   = $clog2(QDEPTH);
    localparam int CNT_W = QAW + 1;
    localparam int IDX_W = BG_W + BA_W;
    localparam int NB    = 1 << IDX_W;

    localparam logic [2:0] CMD_ACT0 = 3'd0;
    localparam logic [2:0] CMD_ACT1 = 3'd1;
    localparam logic [2:0] CMD_RD0  = 3'd2;
    localparam logic [2:0] CMD_RD1  = 3'd3;
    localparam logic [2:0] CMD_WR0  = 3'd4;
    localparam logic [2:0] CMD_WR1  = 3'd5;
    localparam logic [2:0] CMD_PRE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_ACT0, S_ACT1, S_CAS0, S_CAS1, S_WAIT, S_PRE
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [CORE_W-1:0] core;
        logic [BG_W-1:0]   bg;
        logic [BA_W-1:0]   ba;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } entry_t;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    entry_t            mem_q [QDEPTH];
    logic [CNT_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic              phase_q, phase_d;
    state_t            state_q, state_d, step;
    logic [TW-1:0]     rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d, cas_q, cas_d, wr_q, wr_d;
    logic [NB-1:0]     tbl_vld_q, tbl_vld_d;
    logic [ROW_W-1:0]  tbl_row_q [NB];
    logic [ROW_W-1:0]  tbl_row_d [NB];
    logic [CORE_W-1:0] cur_core_q, cur_core_d;
    logic [BG_W-1:0]   cur_bg_q, cur_bg_d;
    logic [BA_W-1:0]   cur_ba_q, cur_ba_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [2:0]        cmd_code_q, cmd_code_d;
    logic [BG_W-1:0]   cmd_bg_q, cmd_bg_d;
    logic [BA_W-1:0]   cmd_ba_q, cmd_ba_d;
    logic [ROW_W-1:0]  cmd_addr_q, cmd_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CORE_W-1:0] rsp_core_q, rsp_core_d;
    logic              err_drop_q, err_drop_d;

    entry_t            head, new_entry;
    logic              head_vld, full, accept, push, pop, done, lkp_vld;
    logic [ROW_W-1:0]  lkp_row;
    logic [IDX_W-1:0]  head_idx, cur_idx, pre_idx;

    assign count     = wptr_q - rptr_q;
    assign head      = mem_q[rptr_q[QAW-1:0]];
    assign head_vld  = (count != '0);
    assign full      = (count == CNT_W'(QDEPTH));
    assign accept    = req_valid && !full;
    assign push      = accept && (req_opn != 2'd3);
    assign head_idx  = {head.bg, head.ba};
    assign cur_idx   = {cur_bg_q, cur_ba_q};
    assign new_entry = '{wr: (req_opn == 2'd1), core: req_core, bg: req_bg,
                         ba: req_ba, row: req_row, col: req_col};

    assign req_ready = !full;
    assign q_count   = count;
    assign busy      = head_vld || (state_q != S_IDLE);
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_bg    = cmd_bg_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_addr  = cmd_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_core  = rsp_core_q;
    assign err_drop  = err_drop_q;

    always_comb begin
        wptr_d     = wptr_q + (push ? CNT_W'(1) : CNT_W'(0));
        rptr_d     = rptr_q + (pop ? CNT_W'(1) : CNT_W'(0));
        err_drop_d = accept && (req_opn == 2'd3);
    end

    // Outputs are registered, so every decision looks one cycle ahead: a command
    // is chosen on an odd cycle (phase_q = 1) against the decremented timers and
    // appears on the following even cycle. Completion, the page-policy choice and
    // the next command are chained here so none of them costs an extra cycle.
    always_comb begin
        phase_d     = ~phase_q;
        rcd_d       = dec(rcd_q);
        ras_d       = dec(ras_q);
        rp_d        = dec(rp_q);
        cas_d       = dec(cas_q);
        wr_d        = dec(wr_q);
        tbl_vld_d   = tbl_vld_q;
        tbl_row_d   = tbl_row_q;
        cur_core_d  = cur_core_q;
        cur_bg_d    = cur_bg_q;
        cur_ba_d    = cur_ba_q;
        cur_row_d   = cur_row_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = '0;
        cmd_bg_d    = '0;
        cmd_ba_d    = '0;
        cmd_addr_d  = '0;
        pop         = 1'b0;

        done        = (state_q == S_WAIT) && (dec(cas_q) == '0);
        rsp_valid_d = done;
        rsp_core_d  = done ? cur_core_q : '0;

        lkp_vld = tbl_vld_q[head_idx];
        lkp_row = tbl_row_q[head_idx];
        step    = state_q;
        if (done) begin
            if (OPEN_PAGE != 0) begin
                tbl_vld_d[cur_idx] = 1'b1;
                tbl_row_d[cur_idx] = cur_row_q;
                if (cur_idx == head_idx) begin
                    lkp_vld = 1'b1;
                    lkp_row = cur_row_q;
                end
                step = S_IDLE;
            end else begin
                step = S_PRE;
            end
        end

        if (step == S_IDLE && head_vld) begin
            if (OPEN_PAGE == 0 || !lkp_vld) begin
                step = S_ACT0;
            end else if (lkp_row == head.row) begin
                step = S_CAS0;
            end else begin
                step     = S_PRE;
                cur_bg_d = head.bg;
                cur_ba_d = head.ba;
            end
        end
        pre_idx = {cur_bg_d, cur_ba_d};
        state_d = step;

        if (phase_q) begin
            case (step)
                S_ACT0: begin
                    if (dec(rp_q) == '0) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = CMD_ACT0;
                        cmd_bg_d    = head.bg;
                        cmd_ba_d    = head.ba;
                        cmd_addr_d  = head.row;
                        rcd_d       = TW'(T_RCD);
                        ras_d       = TW'(T_RAS);
                        state_d     = S_ACT1;
                    end
                end
                S_ACT1: begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = CMD_ACT1;
                    cmd_bg_d    = head.bg;
                    cmd_ba_d    = head.ba;
                    cmd_addr_d  = head.row;
                    state_d     = S_CAS0;
                end
                S_CAS0: begin
                    if (dec(rcd_q) == '0) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = head.wr ? CMD_WR0 : CMD_RD0;
                        cmd_bg_d    = head.bg;
                        cmd_ba_d    = head.ba;
                        cmd_addr_d  = ROW_W'(head.col);
                        cas_d       = head.wr ? TW'(T_CWD + T_BURST) : TW'(T_CAS + T_BURST);
                        if (head.wr) begin
                            wr_d = TW'(T_CWD + T_BURST + T_WR);
                        end
                        state_d = S_CAS1;
                    end
                end
                S_CAS1: begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = head.wr ? CMD_WR1 : CMD_RD1;
                    cmd_bg_d    = head.bg;
                    cmd_ba_d    = head.ba;
                    cmd_addr_d  = ROW_W'(head.col);
                    pop         = 1'b1;
                    cur_core_d  = head.core;
                    cur_bg_d    = head.bg;
                    cur_ba_d    = head.ba;
                    cur_row_d   = head.row;
                    state_d     = S_WAIT;
                end
                S_PRE: begin
                    if (dec(ras_q) == '0 && dec(wr_q) == '0) begin
                        cmd_valid_d        = 1'b1;
                        cmd_code_d         = CMD_PRE;
                        cmd_bg_d           = cur_bg_d;
                        cmd_ba_d           = cur_ba_d;
                        rp_d               = TW'(T_RP);
                        tbl_vld_d[pre_idx] = 1'b0;
                        state_d            = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[QAW-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            phase_q     <= 1'b0;
            state_q     <= S_IDLE;
            rcd_q       <= '0;
            ras_q       <= '0;
            rp_q        <= '0;
            cas_q       <= '0;
            wr_q        <= '0;
            tbl_vld_q   <= '0;
            tbl_row_q   <= '{default: '0};
            cur_core_q  <= '0;
            cur_bg_q    <= '0;
            cur_ba_q    <= '0;
            cur_row_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_ba_q    <= '0;
            cmd_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_core_q  <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            rcd_q       <= rcd_d;
            ras_q       <= ras_d;
            rp_q        <= rp_d;
            cas_q       <= cas_d;
            wr_q        <= wr_d;
            tbl_vld_q   <= tbl_vld_d;
            tbl_row_q   <= tbl_row_d;
            cur_core_q  <= cur_core_d;
            cur_bg_q    <= cur_bg_d;
            cur_ba_q    <= cur_ba_d;
            cur_row_q   <= cur_row_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_addr_q  <= cmd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_core_q  <= rsp_core_d;
            err_drop_q  <= err_drop_d;
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_sched.sv
// Directed bench for ddr5_cmd_sched: closed-page and open-page instances,
// command/response logs compared against hand-computed cycle tables.
module tb_ddr5_cmd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_cp, valid_op;
    logic [1:0]  opn;
    logic [2:0]  core, bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;

    logic        ready_cp, cmdv_cp, rspv_cp, err_cp, busy_cp;
    logic [2:0]  code_cp, cbg_cp, rspc_cp;
    logic [1:0]  cba_cp;
    logic [15:0] addr_cp;
    logic [4:0]  qc_cp;
    logic        ready_op, cmdv_op, rspv_op, err_op, busy_op;
    logic [2:0]  code_op, cbg_op, rspc_op;
    logic [1:0]  cba_op;
    logic [15:0] addr_op;
    logic [4:0]  qc_op;

    int cyc;
    int checks = 0;
    int failures = 0;

    typedef struct { int cyc; logic [2:0] code; logic [2:0] bg; logic [1:0] ba; logic [15:0] addr; } cmd_ev_t;
    typedef struct { int cyc; logic [2:0] core; } rsp_ev_t;
    cmd_ev_t cq_cp[$], cq_op[$];
    rsp_ev_t rq_cp[$], rq_op[$];

    always #5 clk = ~clk;

    ddr5_cmd_sched #(.OPEN_PAGE(0)) u_cp (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_cp), .req_ready(ready_cp),
        .req_opn(opn), .req_core(core), .req_bg(bg), .req_ba(ba), .req_row(row), .req_col(col),
        .cmd_valid(cmdv_cp), .cmd_code(code_cp), .cmd_bg(cbg_cp), .cmd_ba(cba_cp), .cmd_addr(addr_cp),
        .rsp_valid(rspv_cp), .rsp_core(rspc_cp), .err_drop(err_cp), .q_count(qc_cp), .busy(busy_cp)
    );

    ddr5_cmd_sched #(.OPEN_PAGE(1)) u_op (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_op), .req_ready(ready_op),
        .req_opn(opn), .req_core(core), .req_bg(bg), .req_ba(ba), .req_row(row), .req_col(col),
        .cmd_valid(cmdv_op), .cmd_code(code_op), .cmd_bg(cbg_op), .cmd_ba(cba_op), .cmd_addr(addr_op),
        .rsp_valid(rspv_op), .rsp_core(rspc_op), .err_drop(err_op), .q_count(qc_op), .busy(busy_op)
    );

    // cycle n = n-th posedge after reset release; cycle 0 is phase 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmdv_cp) cq_cp.push_back('{cyc, code_cp, cbg_cp, cba_cp, addr_cp});
            if (cmdv_op) cq_op.push_back('{cyc, code_op, cbg_op, cba_op, addr_op});
            if (rspv_cp) rq_cp.push_back('{cyc, rspc_cp});
            if (rspv_op) rq_op.push_back('{cyc, rspc_op});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic longint pk(input int c, input logic [2:0] cd, input logic [2:0] b,
                                  input logic [1:0] a, input logic [15:0] ad);
        return {24'd0, c[15:0], cd, b, a, ad};
    endfunction

    task automatic chk_cmd(input bit op, input int idx, input int ecyc, input logic [2:0] ecode,
                           input logic [2:0] ebg, input logic [1:0] eba, input logic [15:0] eaddr);
        cmd_ev_t e;
        longint  a = -1;
        if (op && idx < cq_op.size()) begin
            e = cq_op[idx];
            a = pk(e.cyc, e.code, e.bg, e.ba, e.addr);
        end else if (!op && idx < cq_cp.size()) begin
            e = cq_cp[idx];
            a = pk(e.cyc, e.code, e.bg, e.ba, e.addr);
        end
        chk($sformatf("%s_cmd%0d{cyc,code,bg,ba,addr}", op ? "op" : "cp", idx), a,
            pk(ecyc, ecode, ebg, eba, eaddr));
    endtask

    task automatic chk_rsp(input bit op, input int idx, input int ecyc, input logic [2:0] ecore);
        rsp_ev_t e;
        longint  a = -1;
        if (op && idx < rq_op.size()) begin
            e = rq_op[idx];
            a = {e.cyc, 5'd0, e.core};
        end else if (!op && idx < rq_cp.size()) begin
            e = rq_cp[idx];
            a = {e.cyc, 5'd0, e.core};
        end
        chk($sformatf("%s_rsp%0d{cyc,core}", op ? "op" : "cp", idx), a, {ecyc, 5'd0, ecore});
    endtask

    task automatic chk_even;
        foreach (cq_cp[i]) chk("cp_cmd_even_cycle", cq_cp[i].cyc % 2, 0);
        foreach (cq_op[i]) chk("op_cmd_even_cycle", cq_op[i].cyc % 2, 0);
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        valid_cp = 1'b0;
        valid_op = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cq_cp.delete(); cq_op.delete(); rq_cp.delete(); rq_op.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic push(input bit op, input logic [1:0] o, input logic [2:0] cr, input logic [2:0] g,
                        input logic [1:0] a, input logic [15:0] r, input logic [9:0] c, output int acc);
        int n = 0;
        opn = o; core = cr; bg = g; ba = a; row = r; col = c;
        if (op) valid_op = 1'b1; else valid_cp = 1'b1;
        while (!(op ? ready_op : ready_cp) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) chk("push_ready_timeout", n, 0);
        acc = cyc;
        @(posedge clk); #1;
        valid_cp = 1'b0;
        valid_op = 1'b0;
    endtask

    typedef struct {
        logic [1:0] opn; logic [2:0] core; logic [2:0] bg; logic [1:0] ba;
        logic [15:0] row; logic [9:0] col; logic [2:0] c0; int rsp; int pre;
    } vec_t;

    initial begin
        vec_t vt[3];
        int   acc;
        vt[0] = '{2'd0, 3'd5, 3'd2, 2'd1, 16'h1A2B, 10'h03F, 3'd2, 176, 176};
        vt[1] = '{2'd1, 3'd1, 3'd7, 2'd3, 16'hFFFF, 10'h3FF, 3'd4, 172, 232};
        vt[2] = '{2'd2, 3'd7, 3'd0, 2'd0, 16'h0000, 10'h000, 3'd2, 176, 176};
        opn = '0; core = '0; bg = '0; ba = '0; row = '0; col = '0;
        valid_cp = 1'b0; valid_op = 1'b0; rst_n = 1'b0;

        #1;
        chk("reset_req_ready", ready_cp, 1);
        chk("reset_outputs", {cmdv_cp, code_cp, addr_cp, rspv_cp, err_cp, qc_cp, busy_cp}, 0);

        // single accesses on the closed-page instance
        for (int i = 0; i < 3; i++) begin
            do_reset;
            push(0, vt[i].opn, vt[i].core, vt[i].bg, vt[i].ba, vt[i].row, vt[i].col, acc);
            wait_cyc(300);
            chk($sformatf("vec%0d_ncmd", i), cq_cp.size(), 5);
            chk_cmd(0, 0, 2,  3'd0, vt[i].bg, vt[i].ba, vt[i].row);
            chk_cmd(0, 1, 4,  3'd1, vt[i].bg, vt[i].ba, vt[i].row);
            chk_cmd(0, 2, 80, vt[i].c0, vt[i].bg, vt[i].ba, {6'd0, vt[i].col});
            chk_cmd(0, 3, 82, vt[i].c0 + 3'd1, vt[i].bg, vt[i].ba, {6'd0, vt[i].col});
            chk_cmd(0, 4, vt[i].pre, 3'd6, vt[i].bg, vt[i].ba, 16'h0);
            chk($sformatf("vec%0d_nrsp", i), rq_cp.size(), 1);
            chk_rsp(0, 0, vt[i].rsp, vt[i].core);
            chk_even;
        end

        // closed page, two reads: second ACT0 waits out tRP after the first PRE
        do_reset;
        push(0, 2'd0, 3'd5, 3'd2, 2'd1, 16'h1A2B, 10'h03F, acc);
        push(0, 2'd0, 3'd2, 3'd0, 2'd3, 16'h0BEE, 10'h012, acc);
        wait_cyc(450);
        chk_cmd(0, 4, 176, 3'd6, 3'd2, 2'd1, 16'h0);
        chk_cmd(0, 5, 254, 3'd0, 3'd0, 2'd3, 16'h0BEE);
        chk_cmd(0, 7, 332, 3'd2, 3'd0, 2'd3, 16'h0012);
        chk_cmd(0, 9, 428, 3'd6, 3'd0, 2'd3, 16'h0);
        chk_rsp(0, 1, 428, 3'd2);
        chk_even;

        // open page: hit, hit, then a row conflict on the same bank
        do_reset;
        push(1, 2'd0, 3'd1, 3'd2, 2'd1, 16'h1A2B, 10'h010, acc);
        push(1, 2'd0, 3'd2, 3'd2, 2'd1, 16'h1A2B, 10'h020, acc);
        push(1, 2'd2, 3'd4, 3'd2, 2'd1, 16'h0001, 10'h030, acc);
        wait_cyc(560);
        chk("open_ncmd", cq_op.size(), 11);
        chk_cmd(1, 0, 2,   3'd0, 3'd2, 2'd1, 16'h1A2B);
        chk_cmd(1, 1, 4,   3'd1, 3'd2, 2'd1, 16'h1A2B);
        chk_cmd(1, 2, 80,  3'd2, 3'd2, 2'd1, 16'h0010);
        chk_cmd(1, 3, 82,  3'd3, 3'd2, 2'd1, 16'h0010);
        chk_cmd(1, 4, 176, 3'd2, 3'd2, 2'd1, 16'h0020);
        chk_cmd(1, 5, 178, 3'd3, 3'd2, 2'd1, 16'h0020);
        chk_cmd(1, 6, 272, 3'd6, 3'd2, 2'd1, 16'h0);
        chk_cmd(1, 7, 350, 3'd0, 3'd2, 2'd1, 16'h0001);
        chk_cmd(1, 8, 352, 3'd1, 3'd2, 2'd1, 16'h0001);
        chk_cmd(1, 9, 428, 3'd2, 3'd2, 2'd1, 16'h0030);
        chk_cmd(1, 10, 430, 3'd3, 3'd2, 2'd1, 16'h0030);
        chk_rsp(1, 0, 176, 3'd1);
        chk_rsp(1, 1, 272, 3'd2);
        chk_rsp(1, 2, 524, 3'd4);
        chk_even;

        // queue full: 16 back-to-back accepts, 17th waits for the head's CAS1
        do_reset;
        for (int i = 0; i < 16; i++) begin
            push(0, 2'd0, 3'(i), 3'd1, 2'd0, 16'h0100, 10'(i), acc);
            chk($sformatf("fill_accept_cycle%0d", i), acc, i);
        end
        chk("full_q_count", qc_cp, 16);
        chk("full_req_ready", ready_cp, 0);
        push(0, 2'd0, 3'd6, 3'd1, 2'd0, 16'h0100, 10'h3A, acc);
        chk("req17_accept_cycle", acc, 82);
        chk("refill_q_count", qc_cp, 16);
        chk("refill_req_ready", ready_cp, 0);

        // illegal opcode is dropped
        do_reset;
        push(0, 2'd3, 3'd2, 3'd4, 2'd2, 16'h7777, 10'h111, acc);
        chk("err_drop_pulse", err_cp, 1);
        chk("err_q_count", qc_cp, 0);
        @(posedge clk); #1;
        chk("err_drop_cleared", err_cp, 0);
        wait_cyc(40);
        chk("err_no_cmd", cq_cp.size(), 0);
        chk("err_not_busy", busy_cp, 0);

        // reset during WAIT_DATA abandons the access and forgets open rows
        do_reset;
        push(1, 2'd0, 3'd3, 3'd1, 2'd2, 16'h0055, 10'h007, acc);
        wait_cyc(100);
        chk("pre_reset_busy", busy_op, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {cmdv_op, code_op, addr_op, rspv_op, rspc_op, err_op, qc_op, busy_op}, 0);
        chk("midreset_ready", ready_op, 1);
        repeat (120) @(posedge clk);
        chk("midreset_no_rsp", rq_op.size(), 0);
        do_reset;
        push(1, 2'd0, 3'd3, 3'd1, 2'd2, 16'h0055, 10'h007, acc);
        wait_cyc(200);
        chk_cmd(1, 0, 2,  3'd0, 3'd1, 2'd2, 16'h0055);
        chk_cmd(1, 2, 80, 3'd2, 3'd1, 2'd2, 16'h0007);
        chk("post_reset_nrsp", rq_op.size(), 1);
        chk_rsp(1, 0, 176, 3'd3);
        chk_even;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr5_cmd_sched.md
Name: ddr5_cmd_sched

Overview:
Synthesizable, parametrised DDR5 single-channel command scheduler that replaces the trace-driven behavioural DIMM model. It accepts decoded memory requests through a valid/ready queue and serves them in order. For each request it emits two-cycle DDR5 commands (ACT0/ACT1, RD0/RD1, WR0/WR1) and PRE. It enforces tRCD/tCAS/tCWD/tBURST/tWR/tRAS/tRP in CPU cycles and supports either closed-page or open-page policy with a per-bank open-row table.

Parameters:
QDEPTH, 16, request queue depth (power of 2)
CORE_W, 3, core ID width
BG_W, 2-bit..3, bank-group address width (default 3)
BA_W, 2, bank address width
ROW_W, 16, row width
COL_W, 10, column width (COL_W <= ROW_W)
TW, 9, timer width
T_RCD, 78, ACT0 to CAS0 minimum
T_CAS, 80, read CAS latency
T_CWD, 76, write CAS latency
T_BURST, 16, burst length
T_WR, 60, write recovery before PRE
T_RAS, 152, ACT0 to PRE minimum
T_RP, 78, PRE to next ACT0 minimum
OPEN_PAGE, 0, 0 = precharge after every access, 1 = keep row open

Ports:
clk  in  1  CPU clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  queue can accept (= !q_full)
req_opn  in  2  0 = read, 1 = write, 2 = ifetch (read), 3 = illegal
req_core  in  CORE_W  requesting core
req_bg  in  BG_W  bank group
req_ba  in  BA_W  bank
req_row  in  ROW_W  row
req_col  in  COL_W  column
cmd_valid  out  1  command issued this cycle
cmd_code  out  3  0 ACT0, 1 ACT1, 2 RD0, 3 RD1, 4 WR0, 5 WR1, 6 PRE
cmd_bg  out  BG_W  target bank group
cmd_ba  out  BA_W  target bank
cmd_addr  out  ROW_W  row for ACT*, zero-extended column for RD*/WR*, 0 for PRE
rsp_valid  out  1  one-cycle pulse when the access's data burst completes
rsp_core  out  CORE_W  core of the completed access
err_drop  out  1  one-cycle pulse when an opn = 3 request is discarded
q_count  out  $clog2(QDEPTH)+1  queue occupancy
busy  out  1  queue non-empty or FSM not in IDLE

Behaviour:
- Reset (asynchronous): all outputs 0 except req_ready = 1. Queue is emptied, open-row table is invalidated, all timers are 0, phase = 0, FSM goes to IDLE. A reset mid-operation abandons any in-flight access and never produces rsp_valid for it.
- Phase: phase toggles every cycle and is 0 on the first cycle after reset. Commands are issued only when phase = 0 (DRAM clock = CPU/2). cmd_valid is never high on odd cycles.
- Enqueue: a request is accepted when req_valid && req_ready at a clock edge. An opn = 3 request completes the handshake, is not stored, and pulses err_drop on the next cycle. An accepted entry is visible as head on the following cycle. Push while full is impossible because ready depends only on full.
- The head entry remains in the queue until its CAS1 issues. The head is popped on the same edge as CAS1, so q_count decrements then.
- Timers (count down to 0, saturate):
  - rcd_t: loaded with T_RCD at ACT0.
  - ras_t: loaded with T_RAS at ACT0.
  - rp_t: loaded with T_RP at PRE.
  - cas_t: loaded at CAS0 with T_CAS+T_BURST for a read, or T_CWD+T_BURST for a write.
  - wr_t: loaded with T_CWD+T_BURST+T_WR at WR0.
  - A load and its decrement do not coexist; the loaded value takes effect next cycle.
- FSM states: IDLE, ACT0, ACT1, CAS0, CAS1, WAIT_DATA, PRE.
  - IDLE: leave when the head is valid and phase = 0, and choose the next step by policy.
  - OPEN_PAGE = 0: ACT0 when rp_t = 0.
  - OPEN_PAGE = 1, open-row table lookup on {bg, ba}:
    - Hit (valid and same row): CAS0.
    - Bank closed: ACT0 when rp_t = 0.
    - Conflict (different row open): PRE when ras_t = 0 and wr_t = 0, then ACT0.
  - ACT0 -> ACT1 on the next even cycle. ACT1 -> CAS0 when rcd_t = 0 on an even cycle. CAS0 -> CAS1 on the next even cycle.
  - CAS1 -> WAIT_DATA. When cas_t reaches 0, rsp_valid pulses for that cycle with rsp_core = the access's core.
    - OPEN_PAGE = 0: go to PRE, which issues at the first even cycle with ras_t = 0 and wr_t = 0.
    - OPEN_PAGE = 1: mark {bg, ba} open with this row and return to IDLE.
  - PRE clears that bank's table entry.
- Single access in flight; commands never overlap. The rp_t and ras_t timers are global, covering the most recent PRE and ACT0.
- When a timer expires on an odd cycle, the command issues on the following even cycle.

Test Plan:
1. OPEN_PAGE = 0: read accepted at cycle 0 (bg 2, ba 1, row 0x1A2B, col 0x3F) -> ACT0 at 2, ACT1 at 4, RD0 at 80, RD1 at 82, rsp_valid at 176, PRE at 176. A second request's ACT0 issues no earlier than 254.
2. OPEN_PAGE = 0: write at cycle 0 -> ACT0 at 2, WR0 at 80, WR1 at 82, rsp_valid at 172, PRE at 232, cmd_addr = 0x003F on WR0/WR1.
3. OPEN_PAGE = 1: two reads to the same bank and row -> second RD0 at 176 with no PRE or ACT between. A third read to the same bank, row 0x0001, produces PRE at 272, ACT0 at 350, RD0 at 428.
4. Hold the head's ACT waiting, push 17 requests back-to-back -> req_ready drops after the 16th accept, q_count = 16, the 17th is not accepted until the head's CAS1.
5. opn = 3 request -> err_drop pulses one cycle, q_count is unchanged, no command issues.
6. Assert rst_n at cycle 100 during WAIT_DATA -> all outputs 0 immediately and no rsp_valid. After release, a request to the previously open row issues ACT0 (not a row hit).
